arb_mux_n: RTL and testbench



---
 rtl/arb_mux_pkg.sv | 31 +++
 rtl/arb_mux_n_rr_pick.sv | 58 +++++
 rtl/arb_mux_n.sv | 109 ++++++++++
 tb/tb_arb_mux_n.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux_pkg
// Description : Shared constants, output-register state encoding and the
//               clog2 helper for the arbitrating multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_mux_pkg;

    // Legal channel-count range for arb_mux_n
    localparam int N_MIN = 2;
    localparam int N_MAX = 16;

    // Output register occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Ceiling log2, minimum result 1 so a 2-channel index is one bit wide
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_mux_n_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational request picker. With ARB_MUX_ROUND_ROBIN_EN
//               defined the search starts at ptr and wraps upward; otherwise
//               channel 0 has fixed highest priority and ptr is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import arb_mux_pkg::*;
#(
    parameter int N    = 2,
    parameter int SELW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

`ifdef ARB_MUX_ROUND_ROBIN_EN
    // Walk downward from the farthest candidate so the one closest to ptr wins
    always_comb begin
        int idx;
        idx     = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                gnt_idx = SELW'(idx);
                gnt_any = 1'b1;
            end
        end
    end
`else
    // ptr is not consulted in fixed-priority mode
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Lowest active index wins
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                gnt_idx = SELW'(k);
                gnt_any = 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/arb_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux_n
// Description : N-channel arbitrating multiplexer with one registered output
//               stage and valid/ready handshakes on every port.
//               Macro ARB_MUX_ROUND_ROBIN_EN selects round-robin arbitration;
//               left undefined, channel 0 has fixed highest priority.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_mux_n
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 2,
    parameter int SELW  = clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [SELW-1:0]  ptr_cur;
    logic [SELW-1:0]  gnt_idx;
    logic             gnt_any;
    logic             load;
    logic             xfer;

`ifdef ARB_MUX_ROUND_ROBIN_EN
    logic [SELW-1:0]  ptr_q, ptr_d;
    assign ptr_cur = ptr_q;
`else
    assign ptr_cur = '0;
`endif

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req     (in_valid),
        .ptr     (ptr_cur),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Handshake and next-state for the output register; a beat moves whenever
    // the register is empty or being drained on the same edge
    always_comb begin
        load     = (state_q == ST_EMPTY) || out_ready;
        xfer     = gnt_any && load;
        in_ready = xfer ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;
        state_d  = state_q;
        data_d   = data_q;
        sel_d    = sel_q;
        if (load) begin
            state_d = xfer ? ST_FULL : ST_EMPTY;
        end
        if (xfer) begin
            data_d = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
            sel_d  = gnt_idx;
        end
    end

`ifdef ARB_MUX_ROUND_ROBIN_EN
    // Priority moves to the channel just after the winner, wrapping at N-1
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Arbiter pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Output register; reset discards any held beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_mux_n
// Description : Randomized scoreboard bench for arb_mux_n (N=4, WIDTH=32).
//               Follows ARB_MUX_ROUND_ROBIN_EN in the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_mux_n;

    localparam int N     = 4;
    localparam int WIDTH = 32;
    localparam int SELW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_ready;

    always #10 clk = ~clk;

    arb_mux_n #(
        .WIDTH (WIDTH),
        .N     (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [SELW-1:0]  sel;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t            sb[$];
    int               tests = 0;
    int               fails = 0;
    bit [N-1:0]       v;
    logic [WIDTH-1:0] d [N];
    int               mptr   = 0;
    bit               mfull  = 1'b0;
    int               last_g = -1;
    bit               mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first requester found scanning up from the start
    // point with wrap; fixed priority always starts the scan at channel 0
    function automatic int pick(input bit [N-1:0] req, input int start);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive();
        in_valid = v;
        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = d[i];
    endtask

    // One cycle of stimulus, called on a falling edge
    task automatic step(input int p_req, input int p_keep, input int p_rdy);
        int         g;
        bit         load;
        logic [N-1:0] exp_rdy;
        for (int i = 0; i < N; i++) begin
            if (!v[i] && ($urandom_range(99) < p_req)) begin
                v[i] = 1'b1;
                d[i] = $urandom;
            end
        end
        out_ready = ($urandom_range(99) < p_rdy);
        drive();
        #2;
        load = !mfull || out_ready;
        g    = pick(v, mptr);
        exp_rdy = '0;
        if (g >= 0 && load) exp_rdy[g] = 1'b1;
        check("in_ready", in_ready, exp_rdy);
        last_g = -1;
        if (g >= 0 && load) begin
            sb.push_back('{sel: g[SELW-1:0], data: d[g]});
            last_g = g;
`ifdef ARB_MUX_ROUND_ROBIN_EN
            mptr = (g + 1) % N;
`endif
            if ($urandom_range(99) < p_keep) d[g] = $urandom;
            else v[g] = 1'b0;
        end
        if (load) mfull = (g >= 0);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse between clock edges, checked with no edge
    task automatic do_reset();
        #3;
        in_valid  = '0;
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sel", out_sel, 0);
        sb.delete();
        mfull = 1'b0;
        mptr  = 0;
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: compare the presented beat against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                check("out_valid", out_valid, sb.size() != 0);
                if (out_valid && sb.size() != 0) begin
                    check("out_data", out_data, sb[0].data);
                    check("out_sel", out_sel, sb[0].sel);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int exp_g;
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        v         = '0;
        for (int i = 0; i < N; i++) d[i] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_out_valid", out_valid, 0);
        mon_en = 1'b1;

        // Fill the output register with DEADBEEF, stall, then reset
        v[0] = 1'b1; d[0] = 32'hDEADBEEF;
        step(0, 0, 100);
        step(0, 0, 0);
        step(0, 0, 0);
        do_reset();

        // Single source on channel 1
        v[1] = 1'b1; d[1] = 32'h1234;
        step(0, 0, 100);
        step(0, 0, 100);

        // Wrap to channel 0, then backpressure with channel 1 waiting
        v[0] = 1'b1; d[0] = 32'hAAAA;
        step(0, 0, 100);
        v[1] = 1'b1; d[1] = 32'h5555;
        repeat (3) step(0, 0, 0);
        step(0, 0, 100);
        repeat (2) step(0, 0, 100);

        // Contention from reset: all channels held valid
        do_reset();
        v = '1;
        for (int i = 0; i < N; i++) d[i] = $urandom;
        for (int k = 0; k < 5; k++) begin
            step(0, 100, 100);
`ifdef ARB_MUX_ROUND_ROBIN_EN
            exp_g = k % N;
`else
            exp_g = 0;
`endif
            check("contention_grant", last_g, exp_g);
        end
        repeat (6) step(0, 0, 100);

        // Random traffic with one mid-stream reset
        for (int it = 0; it < 2000; it++) begin
            if (it == 1000) do_reset();
            step(30, 50, 70);
        end
        repeat (20) step(0, 0, 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
